// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line into the receiver and the byte/status pulses out of it.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_error;
  logic       parity_error;
  logic       busy;

  modport master (output rx, input rx_data, rx_ready, frame_error, parity_error, busy);
  modport slave  (input rx, output rx_data, rx_ready, frame_error, parity_error, busy);
endinterface

// File: rtl/uart_rx_receiver.sv
// 8N1 UART receiver with mid-bit sampling and break detection.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_receiver #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_M1       = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1      = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q;
  logic        s1_q, rx_s_q;
  logic [1:0]  fill_q;
  logic        arm_q, arm_d;
  logic        ok_q, ok_d, fe_q, fe_d;
  logic        rx_ready_q, frame_error_q;
`ifdef UART_RX_PARITY_EN
  logic        perr_q, perr_d, pe_q, pe_d, parity_error_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q          <= 1'b1;
      rx_s_q        <= 1'b1;
      fill_q        <= 2'b00;
      arm_q         <= 1'b0;
      state_q       <= IDLE;
      timer_q       <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      ok_q          <= 1'b0;
      fe_q          <= 1'b0;
      rx_ready_q    <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q         <= 1'b0;
      pe_q           <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      s1_q          <= bus.rx;
      rx_s_q        <= s1_q;
      fill_q        <= {fill_q[0], 1'b1};
      arm_q         <= arm_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      ok_q          <= ok_d;
      fe_q          <= fe_d;
      rx_ready_q    <= ok_q;
      frame_error_q <= fe_q;
      if (ok_q) rx_data_q <= shift_q;
`ifdef UART_RX_PARITY_EN
      perr_q         <= perr_d;
      pe_q           <= pe_d;
      parity_error_q <= pe_q;
`endif
    end
  end

  // The synchronizer resets to idle-high, so a line held low across reset must be
  // seen high once through a refilled synchronizer before a start bit is accepted.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    arm_d   = arm_q | (fill_q[1] & rx_s_q);
    ok_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif
    case (state_q)
      IDLE: if (arm_q && !rx_s_q) begin
        state_d = START;
        timer_d = '0;
      end
      START: if (timer_q == HALF_M1) begin
        timer_d = '0;
        idx_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
      end else timer_d = timer_q + 16'd1;
      DATA: if (timer_q == BIT_M1) begin
        timer_d        = '0;
        shift_d[idx_q] = rx_s_q;
        idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end else timer_d = timer_q + 16'd1;
`ifdef UART_RX_PARITY_EN
      PARITY: if (timer_q == BIT_M1) begin
        timer_d = '0;
        perr_d  = rx_s_q != ^shift_q;
        state_d = STOP;
      end else timer_d = timer_q + 16'd1;
`endif
      STOP: if (timer_q == BIT_M1) begin
        timer_d = '0;
        if (!rx_s_q) begin
          fe_d    = 1'b1;
          state_d = BREAK;
        end else begin
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          pe_d    = perr_q;
          ok_d    = !perr_q;
`else
          ok_d    = 1'b1;
`endif
        end
      end else timer_d = timer_q + 16'd1;
      BREAK: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_ready    = rx_ready_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error = parity_error_q;
`else
  assign bus.parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_receiver.sv
// Scoreboard bench: frames push expected events, a negedge monitor pops and compares.
module tb_uart_rx_receiver;
  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int C      = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // frame latency from the line edge: half bit + data/parity/stop bits + 1, plus 2 sync stages
  localparam int LAT = C / 2 + (9 + PBITS) * C + 1 + 2;

  typedef enum int {EV_OK = 0, EV_FE = 1, EV_PE = 2} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
    int         t_fall;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_if bus();
  uart_rx_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input int act, input int req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
  endtask

  task automatic bit_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rx low after a bad stop bit so the caller controls the break length.
  task automatic send(input logic [7:0] d, input bit stop, input bit bad_par);
    exp_t e;
    bit   bp;
`ifdef UART_RX_PARITY_EN
    bp = bad_par;
`else
    bp = 1'b0;
`endif
    e.t_fall = cyc;
    if (!stop)   e.kind = EV_FE;
    else if (bp) e.kind = EV_PE;
    else         e.kind = EV_OK;
    if (e.kind == EV_OK) last_good = d;
    e.data = last_good;
    q.push_back(e);
    bus.rx = 1'b0;
    bit_wait(C);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      bit_wait(C);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = (^d) ^ bp;
    bit_wait(C);
`endif
    bus.rx = stop;
    bit_wait(C);
  endtask

  always @(negedge clk) begin
    int   np;
    int   kind;
    exp_t e;
    np = int'(bus.rx_ready) + int'(bus.frame_error) + int'(bus.parity_error);
    if (!reset && np != 0) begin
      check("pulse_exclusive", np == 1, np, 1);
      kind = bus.rx_ready ? 0 : (bus.frame_error ? 1 : 2);
      check("pulse_expected", q.size() != 0, kind, -1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pulse_kind", kind == int'(e.kind), kind, int'(e.kind));
        check("rx_data", bus.rx_data == e.data, int'(bus.rx_data), int'(e.data));
        if (bus.rx_ready)
          check("latency", (cyc - e.t_fall - LAT) <= 2 && (cyc - e.t_fall - LAT) >= -2,
                cyc - e.t_fall, LAT);
      end
    end
  end

  bit prev_p = 1'b0;
  always @(negedge clk) begin
    bit cur;
    cur = bus.rx_ready | bus.frame_error | bus.parity_error;
    if (!reset && cur && prev_p) check("pulse_back_to_back", 1'b0, 1, 0);
    prev_p = cur & ~reset;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.rx = 1'b1;
    reset  = 1'b1;
    bit_wait(3);
    check("reset_rx_data", bus.rx_data == 8'h00, int'(bus.rx_data), 0);
    check("reset_busy", bus.busy == 1'b0, int'(bus.busy), 0);
    check("reset_pulses", {bus.rx_ready, bus.frame_error, bus.parity_error} == 3'b000,
          int'({bus.rx_ready, bus.frame_error, bus.parity_error}), 0);
    reset = 1'b0;
    bit_wait(4);

    send(8'h55, 1'b1, 1'b0);
    bit_wait(2 * C);
    check("idle_busy", bus.busy == 1'b0, int'(bus.busy), 0);

    // short low glitch, shorter than half a bit
    bus.rx = 1'b0;
    bit_wait(C / 2 - 3);
    bus.rx = 1'b1;
    bit_wait(C);
    check("glitch_busy", bus.busy == 1'b0, int'(bus.busy), 0);

    send(8'hA5, 1'b1, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    bit_wait(6 * C);
    check("break_busy", bus.busy == 1'b1, int'(bus.busy), 1);
    check("break_data", bus.rx_data == 8'hA5, int'(bus.rx_data), 8'hA5);
    bus.rx = 1'b1;
    bit_wait(5);
    check("break_exit_busy", bus.busy == 1'b0, int'(bus.busy), 0);

    send(8'hFF, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    bit_wait(2 * C);

    // reset in the middle of bit 4 of 0x81; the rest of the frame must be ignored
    begin
      logic [7:0] d;
      d = 8'h81;
      bus.rx = 1'b0;
      bit_wait(C);
      for (int i = 0; i < 8; i++) begin
        bus.rx = d[i];
        if (i == 4) begin
          bit_wait(C / 2);
          reset = 1'b1;
          bit_wait(2);
          reset = 1'b0;
          last_good = 8'h00;
          bit_wait(C - C / 2 - 2);
        end else bit_wait(C);
      end
      bus.rx = 1'b1;
      bit_wait(2 * C);
      check("abort_rx_data", bus.rx_data == 8'h00, int'(bus.rx_data), 0);
      check("abort_busy", bus.busy == 1'b0, int'(bus.busy), 0);
    end
    send(8'h42, 1'b1, 1'b0);
    bit_wait(2 * C);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1);
    bit_wait(C);
    send(8'h07, 1'b1, 1'b0);
    bit_wait(C);
`endif

    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      int         r;
      d = 8'($urandom);
      r = $urandom_range(0, 9);
      send(d, r != 0, r == 1);
      if (r == 0) begin
        bit_wait($urandom_range(C, 3 * C));
        bus.rx = 1'b1;
        bit_wait(C);
      end else if ($urandom_range(0, 1) == 1) begin
        bit_wait($urandom_range(1, 3 * C));
      end
    end

    bit_wait(3 * C);
    check("scoreboard_drained", q.size() == 0, q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
